// File: rtl/cpu_decode_stage.sv
// Decode stage: splits the instruction into fields, reads the 16-entry scalar register file
// (write-back and same-cycle bypass included), detects load-use hazards, registers the D/E entry.
module cpu_decode_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMM_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [29:0]       instr_in,
  input  logic [31:0]       pc_in,
  input  logic              instr_valid_in,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [3:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall_out,
  output logic              de_valid,
  output logic [31:0]       de_pc,
  output logic [1:0]        de_op_type,
  output logic [3:0]        de_opcode,
  output logic [3:0]        de_rd,
  output logic [3:0]        de_rs1,
  output logic [3:0]        de_rs2,
  output logic [DATA_W-1:0] de_rs1_data,
  output logic [DATA_W-1:0] de_rs2_data,
  output logic [DATA_W-1:0] de_imm,
  output logic              de_reg_we,
  output logic              de_mem_read,
  output logic              de_mem_write,
  output logic              de_branch,
  output logic              de_vector,
  output logic              de_alu_imm,
  output logic              de_illegal
);

  localparam int unsigned NREG = 16;

  typedef enum logic [1:0] {
    OP_ARITH  = 2'b00,
    OP_MEM    = 2'b01,
    OP_BRANCH = 2'b10,
    OP_VECTOR = 2'b11
  } op_type_e;

  logic [DATA_W-1:0] r_regs [NREG];

  logic [1:0]        w_op_type;
  logic [3:0]        w_opcode;
  logic [3:0]        w_rd;
  logic [3:0]        w_rs1;
  logic [3:0]        w_rs2;
  logic [IMM_W-1:0]  w_imm_raw;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_rs1_data;
  logic [DATA_W-1:0] w_rs2_data;
  logic              w_reg_we, w_mem_read, w_mem_write, w_branch, w_vector, w_alu_imm, w_illegal;
  logic              w_hazard;

  logic              r_de_valid;
  logic [31:0]       r_de_pc;
  logic [1:0]        r_de_op_type;
  logic [3:0]        r_de_opcode, r_de_rd, r_de_rs1, r_de_rs2;
  logic [DATA_W-1:0] r_de_rs1_data, r_de_rs2_data, r_de_imm;
  logic              r_de_reg_we, r_de_mem_read, r_de_mem_write, r_de_branch;
  logic              r_de_vector, r_de_alu_imm, r_de_illegal;

  assign w_op_type = instr_in[29:28];
  assign w_opcode  = instr_in[27:24];
  assign w_rd      = instr_in[23:20];
  assign w_rs1     = instr_in[19:16];
  assign w_rs2     = instr_in[15:12];
  assign w_imm_raw = instr_in[IMM_W-1:0];
  assign w_imm     = {{(DATA_W-IMM_W){w_imm_raw[IMM_W-1]}}, w_imm_raw};

  // Register file; R0 is never written so it stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (wb_we && (wb_addr != 4'd0)) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  // Reads with same-cycle write-back bypass.
  always_comb begin
    w_rs1_data = r_regs[w_rs1];
    w_rs2_data = r_regs[w_rs2];
    if (w_rs1 == 4'd0) w_rs1_data = '0;
    else if (wb_we && (wb_addr == w_rs1)) w_rs1_data = wb_data;
    if (w_rs2 == 4'd0) w_rs2_data = '0;
    else if (wb_we && (wb_addr == w_rs2)) w_rs2_data = wb_data;
  end

  // Control decode; an invalid input slot decodes to all-zero control.
  always_comb begin
    w_reg_we    = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_branch    = 1'b0;
    w_vector    = 1'b0;
    w_alu_imm   = 1'b0;
    w_illegal   = 1'b0;
    if (instr_valid_in) begin
      unique case (op_type_e'(w_op_type))
        OP_ARITH: begin
          w_reg_we  = 1'b1;
          w_alu_imm = w_opcode[3];
        end
        OP_MEM: begin
          if (w_opcode == 4'b0000) begin
            w_reg_we   = 1'b1;
            w_mem_read = 1'b1;
            w_alu_imm  = 1'b1;
          end else if (w_opcode == 4'b0001) begin
            w_mem_write = 1'b1;
            w_alu_imm   = 1'b1;
          end else begin
            w_illegal = 1'b1;
          end
        end
        OP_BRANCH: begin
          w_branch  = 1'b1;
          w_alu_imm = 1'b1;
        end
        OP_VECTOR: w_vector = 1'b1;
        default: ;
      endcase
    end
  end

  // Both source fields are compared whether or not the instruction uses them.
  assign w_hazard  = r_de_valid & r_de_mem_read & (r_de_rd != 4'd0) & instr_valid_in &
                     ((r_de_rd == w_rs1) | (r_de_rd == w_rs2));
  assign stall_out = w_hazard & ~flush;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_de_valid     <= 1'b0;
      r_de_pc        <= '0;
      r_de_op_type   <= '0;
      r_de_opcode    <= '0;
      r_de_rd        <= '0;
      r_de_rs1       <= '0;
      r_de_rs2       <= '0;
      r_de_rs1_data  <= '0;
      r_de_rs2_data  <= '0;
      r_de_imm       <= '0;
      r_de_reg_we    <= 1'b0;
      r_de_mem_read  <= 1'b0;
      r_de_mem_write <= 1'b0;
      r_de_branch    <= 1'b0;
      r_de_vector    <= 1'b0;
      r_de_alu_imm   <= 1'b0;
      r_de_illegal   <= 1'b0;
    end else if (flush || stall_out) begin
      r_de_valid     <= 1'b0;
      r_de_reg_we    <= 1'b0;
      r_de_mem_read  <= 1'b0;
      r_de_mem_write <= 1'b0;
      r_de_branch    <= 1'b0;
      r_de_vector    <= 1'b0;
      r_de_alu_imm   <= 1'b0;
      r_de_illegal   <= 1'b0;
    end else begin
      r_de_valid     <= instr_valid_in;
      r_de_pc        <= pc_in;
      r_de_op_type   <= w_op_type;
      r_de_opcode    <= w_opcode;
      r_de_rd        <= w_rd;
      r_de_rs1       <= w_rs1;
      r_de_rs2       <= w_rs2;
      r_de_rs1_data  <= w_rs1_data;
      r_de_rs2_data  <= w_rs2_data;
      r_de_imm       <= w_imm;
      r_de_reg_we    <= w_reg_we;
      r_de_mem_read  <= w_mem_read;
      r_de_mem_write <= w_mem_write;
      r_de_branch    <= w_branch;
      r_de_vector    <= w_vector;
      r_de_alu_imm   <= w_alu_imm;
      r_de_illegal   <= w_illegal;
    end
  end

  assign de_valid     = r_de_valid;
  assign de_pc        = r_de_pc;
  assign de_op_type   = r_de_op_type;
  assign de_opcode    = r_de_opcode;
  assign de_rd        = r_de_rd;
  assign de_rs1       = r_de_rs1;
  assign de_rs2       = r_de_rs2;
  assign de_rs1_data  = r_de_rs1_data;
  assign de_rs2_data  = r_de_rs2_data;
  assign de_imm       = r_de_imm;
  assign de_reg_we    = r_de_reg_we;
  assign de_mem_read  = r_de_mem_read;
  assign de_mem_write = r_de_mem_write;
  assign de_branch    = r_de_branch;
  assign de_vector    = r_de_vector;
  assign de_alu_imm   = r_de_alu_imm;
  assign de_illegal   = r_de_illegal;

endmodule

// File: tb/tb_cpu_decode_stage.sv
// Bench for cpu_decode_stage: directed scenarios plus randomized traffic, all checked
// against a cycle-level reference model of the decode stage.
module tb_cpu_decode_stage;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [29:0]       instr_in;
  logic [31:0]       pc_in;
  logic              instr_valid_in;
  logic              flush;
  logic              wb_we;
  logic [3:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              stall_out, de_valid;
  logic [31:0]       de_pc;
  logic [1:0]        de_op_type;
  logic [3:0]        de_opcode, de_rd, de_rs1, de_rs2;
  logic [DATA_W-1:0] de_rs1_data, de_rs2_data, de_imm;
  logic              de_reg_we, de_mem_read, de_mem_write, de_branch, de_vector, de_alu_imm, de_illegal;

  cpu_decode_stage #(.DATA_W(DATA_W), .IMM_W(12)) dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in), .instr_valid_in(instr_valid_in),
    .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .stall_out(stall_out),
    .de_valid(de_valid), .de_pc(de_pc), .de_op_type(de_op_type), .de_opcode(de_opcode),
    .de_rd(de_rd), .de_rs1(de_rs1), .de_rs2(de_rs2), .de_rs1_data(de_rs1_data),
    .de_rs2_data(de_rs2_data), .de_imm(de_imm), .de_reg_we(de_reg_we), .de_mem_read(de_mem_read),
    .de_mem_write(de_mem_write), .de_branch(de_branch), .de_vector(de_vector),
    .de_alu_imm(de_alu_imm), .de_illegal(de_illegal)
  );

  always #5 clk = ~clk;

  // ctl = {reg_we, mem_read, mem_write, branch, vector, alu_imm, illegal}
  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [1:0]  op_type;
    logic [3:0]  opcode, rd, rs1, rs2;
    logic [31:0] d1, d2, imm;
    logic [6:0]  ctl;
  } de_t;

  logic [31:0] m_regs [16];
  de_t         m_de;
  logic        last_stall = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] mk(input logic [1:0] t, input logic [3:0] opc, input logic [3:0] rd,
                                     input logic [3:0] rs1, input logic [3:0] rs2, input logic [11:0] imm);
    return {t, opc, rd, rs1, rs2, imm};
  endfunction

  // Decode rules from the instruction-set definition.
  function automatic logic [6:0] ref_ctl(input logic v, input logic [1:0] t, input logic [3:0] opc);
    if (!v) return 7'b0000000;
    case (t)
      2'd0:    return {1'b1, 4'b0000, opc[3], 1'b0};
      2'd1:    return (opc == 4'd0) ? 7'b1100010 : (opc == 4'd1) ? 7'b0010010 : 7'b0000001;
      2'd2:    return 7'b0001010;
      default: return 7'b0000100;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [3:0] a, input logic we, input logic [3:0] wa,
                                           input logic [31:0] wd);
    if (a == 4'd0) return 32'd0;
    if (we && wa == a) return wd;
    return m_regs[a];
  endfunction

  function automatic logic [6:0] dut_ctl();
    return {de_reg_we, de_mem_read, de_mem_write, de_branch, de_vector, de_alu_imm, de_illegal};
  endfunction

  // One clock: drive inputs, check the combinational stall, advance model and DUT, check D/E.
  task automatic step(input logic r, input logic [29:0] ins, input logic [31:0] pc, input logic v,
                      input logic fl, input logic we, input logic [3:0] wa, input logic [31:0] wd,
                      input string tag);
    logic exp_stall;
    de_t  nx;
    rst = r; instr_in = ins; pc_in = pc; instr_valid_in = v;
    flush = fl; wb_we = we; wb_addr = wa; wb_data = wd;
    #1;
    exp_stall = m_de.valid && m_de.ctl[5] && (m_de.rd != 4'd0) && v &&
                ((m_de.rd == ins[19:16]) || (m_de.rd == ins[15:12])) && !fl;
    check({tag, "_stall"}, 32'(stall_out), 32'(exp_stall));
    last_stall = exp_stall;
    nx = m_de;
    if (!r) begin
      nx = '{valid: 1'b0, pc: '0, op_type: '0, opcode: '0, rd: '0, rs1: '0, rs2: '0,
             d1: '0, d2: '0, imm: '0, ctl: '0};
    end else if (fl || exp_stall) begin
      nx.valid = 1'b0;
      nx.ctl   = '0;
    end else begin
      nx.valid   = v;
      nx.pc      = pc;
      nx.op_type = ins[29:28];
      nx.opcode  = ins[27:24];
      nx.rd      = ins[23:20];
      nx.rs1     = ins[19:16];
      nx.rs2     = ins[15:12];
      nx.d1      = ref_read(ins[19:16], we, wa, wd);
      nx.d2      = ref_read(ins[15:12], we, wa, wd);
      nx.imm     = {{20{ins[11]}}, ins[11:0]};
      nx.ctl     = ref_ctl(v, ins[29:28], ins[27:24]);
    end
    if (!r) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
    end else if (we && wa != 4'd0) begin
      m_regs[wa] = wd;
    end
    @(posedge clk);
    #1;
    m_de = nx;
    check({tag, "_valid"}, 32'(de_valid), 32'(m_de.valid));
    check({tag, "_ctl"}, 32'(dut_ctl()), 32'(m_de.ctl));
    if (m_de.valid || !r) begin
      check({tag, "_pc"}, de_pc, m_de.pc);
      check({tag, "_fields"}, 32'({de_op_type, de_opcode, de_rd, de_rs1, de_rs2}),
            32'({m_de.op_type, m_de.opcode, m_de.rd, m_de.rs1, m_de.rs2}));
      check({tag, "_rs1_data"}, de_rs1_data, m_de.d1);
      check({tag, "_rs2_data"}, de_rs2_data, m_de.d2);
      check({tag, "_imm"}, de_imm, m_de.imm);
    end
  endtask

  function automatic logic [29:0] rand_instr();
    logic [1:0] t;
    logic [3:0] opc;
    t   = 2'($urandom_range(0, 3));
    opc = (t == 2'd1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
    return mk(t, opc, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
              4'($urandom_range(0, 7)), 12'($urandom));
  endfunction

  logic [29:0] cur;
  logic [31:0] cur_pc;
  logic        cur_v;

  initial begin
    for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
    m_de = '{valid: 1'b0, pc: '0, op_type: '0, opcode: '0, rd: '0, rs1: '0, rs2: '0,
             d1: '0, d2: '0, imm: '0, ctl: '0};
    rst = 1'b0; instr_in = '0; pc_in = '0; instr_valid_in = 1'b0;
    flush = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    @(posedge clk); #1;

    // Reset state and first read-back.
    step(1'b0, mk(2'd1, 4'd0, 4'd7, 4'd1, 4'd2, 12'h5), 32'h40, 1'b1, 1'b0, 1'b1, 4'd5, 32'h77, "rst");
    check("rst_de_valid", 32'(de_valid), 32'd0);
    step(1'b1, '0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd5, 32'hAA, "t1_wb");
    step(1'b1, mk(2'd0, 4'd0, 4'd1, 4'd5, 4'd0, 12'hFFF), 32'h100, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, "t1");
    check("t1_rs1_aa", de_rs1_data, 32'hAA);
    check("t1_imm_sext", de_imm, 32'hFFFF_FFFF);
    check("t1_reg_we", 32'(de_reg_we), 32'd1);

    // Bypass and R0 protection.
    step(1'b1, mk(2'd0, 4'd0, 4'd2, 4'd3, 4'd0, 12'h0), 32'h104, 1'b1, 1'b0, 1'b1, 4'd3, 32'h1234, "t2_byp");
    check("t2_bypass", de_rs1_data, 32'h1234);
    step(1'b1, mk(2'd0, 4'd0, 4'd2, 4'd0, 4'd0, 12'h0), 32'h108, 1'b1, 1'b0, 1'b1, 4'd0, 32'hDEAD, "t2_r0a");
    check("t2_r0_same", de_rs1_data, 32'd0);
    step(1'b1, mk(2'd0, 4'd0, 4'd2, 4'd0, 4'd0, 12'h0), 32'h10C, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, "t2_r0b");
    check("t2_r0_after", de_rs1_data, 32'd0);

    // Load-use: exactly one bubble.
    step(1'b1, mk(2'd1, 4'd0, 4'd7, 4'd1, 4'd0, 12'h4), 32'h110, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, "t3_ld");
    step(1'b1, mk(2'd0, 4'd0, 4'd8, 4'd1, 4'd7, 12'h0), 32'h114, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, "t3_use");
    check("t3_bubble", 32'(de_valid), 32'd0);
    step(1'b1, mk(2'd0, 4'd0, 4'd8, 4'd1, 4'd7, 12'h0), 32'h114, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, "t3_rel");
    check("t3_enter", 32'(de_valid), 32'd1);
    check("t3_no_stall", 32'(stall_out), 32'd0);

    // Flush during hazard: no stall, one bubble only.
    step(1'b1, mk(2'd1, 4'd0, 4'd7, 4'd1, 4'd0, 12'h4), 32'h118, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, "t4_ld");
    step(1'b1, mk(2'd0, 4'd0, 4'd8, 4'd7, 4'd0, 12'h0), 32'h11C, 1'b1, 1'b1, 1'b1, 4'd9, 32'h99, "t4_fl");
    check("t4_bubble", 32'(de_valid), 32'd0);
    step(1'b1, mk(2'd0, 4'd0, 4'd8, 4'd7, 4'd9, 12'h0), 32'h200, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, "t4_next");
    check("t4_enter", 32'(de_valid), 32'd1);
    check("t4_wb_commit", de_rs2_data, 32'h99);

    // Decode sweep.
    step(1'b1, mk(2'd0, 4'd8, 4'd1, 4'd2, 4'd2, 12'h1), 32'h300, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, "t5_a8");
    step(1'b1, mk(2'd1, 4'd0, 4'd1, 4'd2, 4'd2, 12'h1), 32'h304, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, "t5_ld");
    step(1'b1, mk(2'd1, 4'd1, 4'd1, 4'd2, 4'd2, 12'h1), 32'h308, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, "t5_st");
    step(1'b1, mk(2'd1, 4'd5, 4'd1, 4'd2, 4'd2, 12'h1), 32'h30C, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, "t5_ill");
    check("t5_illegal_only", 32'(dut_ctl()), 32'h01);
    step(1'b1, mk(2'd2, 4'd3, 4'd1, 4'd2, 4'd2, 12'h1), 32'h310, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, "t5_br");
    step(1'b1, mk(2'd3, 4'd2, 4'd1, 4'd2, 4'd2, 12'h1), 32'h314, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, "t5_vec");
    check("t5_vector", 32'(dut_ctl()), 32'h04);
    step(1'b1, mk(2'd0, 4'd0, 4'd1, 4'd2, 4'd2, 12'h1), 32'h318, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, "t5_inv");

    // Reset mid-stream with a load in D/E.
    step(1'b1, mk(2'd1, 4'd0, 4'd7, 4'd5, 4'd0, 12'h4), 32'h400, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, "t6_ld");
    step(1'b0, mk(2'd0, 4'd0, 4'd8, 4'd7, 4'd0, 12'h0), 32'h404, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, "t6_rst");
    check("t6_ctl_zero", 32'(dut_ctl()), 32'd0);
    check("t6_pc_zero", de_pc, 32'd0);
    for (int i = 0; i < 16; i++)
      step(1'b1, mk(2'd0, 4'd0, 4'd1, 4'(i), 4'(15 - i), 12'h0), 32'h500, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0,
           "t6_rd");

    // Randomized traffic; the instruction is held while stalled, as fetch would.
    cur = rand_instr(); cur_pc = 32'h1000; cur_v = 1'b1;
    for (int k = 0; k < 600; k++) begin
      if (!last_stall) begin
        cur    = rand_instr();
        cur_v  = ($urandom_range(0, 9) != 0);
        cur_pc = cur_pc + 32'd4;
      end
      step(($urandom_range(0, 49) != 0), cur, cur_pc, cur_v, ($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
